// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with valid/allow-in handshake, byte-lane load/store
// alignment and an ID bypass bus. Optional macro MEM_STALL_CNT_EN adds a memory-stall cycle counter.
`ifndef EX_TO_MEM_BUS_WD
`define EX_TO_MEM_BUS_WD 107
`endif
`ifndef MEM_TO_WB_BUS_WD
`define MEM_TO_WB_BUS_WD 70
`endif
`ifndef RDW_BUS_WD
`define RDW_BUS_WD 39
`endif

module mem_stage (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         EX_to_MEM_Valid,
    input  logic [`EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_Bus,
    output logic                         MEM_Allow_in,
    input  logic                         WB_Allow_in,
    output logic                         MEM_to_WB_Valid,
    output logic [`MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_Bus,
    output logic [`RDW_BUS_WD-1:0]       rdw_MEM_Bus,
    output logic [31:0]                  Address,
    output logic                         MemRead,
    output logic                         MemWrite,
    output logic [31:0]                  Write_data,
    output logic [3:0]                   Write_strb,
    input  logic                         Mem_Req_Ready,
    input  logic [31:0]                  Read_data,
    input  logic                         Read_data_Valid,
    output logic                         Read_data_Ready
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [31:0]                  mem_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                       state_r;
    state_t                       state_nxt_s;
    logic [`EX_TO_MEM_BUS_WD-1:0] bus_r;
    logic [31:0]                  load_data_r;

    logic        mem_read_s;
    logic        mem_write_s;
    logic [2:0]  funct3_s;
    logic        wb_wen_s;
    logic [4:0]  waddr_s;
    logic [31:0] alu_s;
    logic [31:0] store_data_s;
    logic [31:0] pc_s;
    logic [1:0]  off_s;
    logic [31:0] final_s;
    logic        accept_s;
    logic        in_is_mem_s;
    logic        mem_valid_s;
    logic        data_ready_s;

    // Byte/half lanes are selected by the low address bits, then sign or zero extended
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        logic [31:0] res_s;
        byte_s = 8'(rdata >> {off, 3'b000});
        half_s = 16'(rdata >> {off[1], 4'b0000});
        case (f3)
            3'b000:  res_s = {{24{byte_s[7]}}, byte_s};
            3'b100:  res_s = {24'h000000, byte_s};
            3'b001:  res_s = {{16{half_s[15]}}, half_s};
            3'b101:  res_s = {16'h0000, half_s};
            default: res_s = rdata;
        endcase
        return res_s;
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] off, input logic [1:0] size);
        logic [3:0] res_s;
        case (size)
            2'b00:   res_s = 4'b0001 << off;
            2'b01:   res_s = 4'b0011 << {off[1], 1'b0};
            default: res_s = 4'b1111;
        endcase
        return res_s;
    endfunction

    assign mem_read_s   = bus_r[106];
    assign mem_write_s  = bus_r[105];
    assign funct3_s     = bus_r[104:102];
    assign wb_wen_s     = bus_r[101];
    assign waddr_s      = bus_r[100:96];
    assign alu_s        = bus_r[95:64];
    assign store_data_s = bus_r[63:32];
    assign pc_s         = bus_r[31:0];
    assign off_s        = alu_s[1:0];

    assign in_is_mem_s  = EX_to_MEM_Bus[106] | EX_to_MEM_Bus[105];
    assign MEM_Allow_in = (state_r == IDLE) | ((state_r == DONE) & WB_Allow_in);
    assign accept_s     = EX_to_MEM_Valid & MEM_Allow_in;
    assign mem_valid_s  = (state_r != IDLE);

    // Next-state logic; a new instruction may enter in the same cycle DONE hands off
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = in_is_mem_s ? REQ : DONE;
                else          state_nxt_s = IDLE;
            end
            REQ: begin
                if (Mem_Req_Ready) state_nxt_s = mem_read_s ? RESP : DONE;
                else               state_nxt_s = REQ;
            end
            RESP: begin
                if (Read_data_Valid) state_nxt_s = DONE;
                else                 state_nxt_s = RESP;
            end
            DONE: begin
                if (WB_Allow_in) begin
                    if (accept_s) state_nxt_s = in_is_mem_s ? REQ : DONE;
                    else          state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight access so late responses are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Instruction payload register, loaded only on handshake
    always_ff @(posedge clk) begin
        if (accept_s) bus_r <= EX_to_MEM_Bus;
    end

    // Extended load data, captured when the response is accepted
    always_ff @(posedge clk) begin
        if ((state_r == RESP) && Read_data_Valid)
            load_data_r <= load_extend(Read_data, off_s, funct3_s);
    end

    assign final_s         = mem_read_s ? load_data_r : alu_s;
    assign data_ready_s    = ~(mem_read_s & ((state_r == REQ) | (state_r == RESP)));
    assign MEM_to_WB_Valid = (state_r == DONE);
    assign MEM_to_WB_Bus   = {wb_wen_s, waddr_s, final_s, pc_s};
    assign rdw_MEM_Bus     = {data_ready_s, mem_valid_s & wb_wen_s, waddr_s, final_s};
    assign Address         = {alu_s[31:2], 2'b00};
    assign MemRead         = (state_r == REQ) & mem_read_s;
    assign MemWrite        = (state_r == REQ) & mem_write_s;
    assign Write_data      = store_data_s << {off_s, 3'b000};
    assign Write_strb      = store_strb(off_s, funct3_s[1:0]);
    assign Read_data_Ready = (state_r == RESP);

`ifdef MEM_STALL_CNT_EN
    // Cycles spent waiting on memory; wraps naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    mem_stall_cnt <= 32'd0;
        else if ((state_r == REQ) || (state_r == RESP)) mem_stall_cnt <= mem_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios then randomized traffic against a
// behavioural byte-lane model with a responsive memory.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         EX_to_MEM_Valid;
    logic [106:0] EX_to_MEM_Bus;
    logic         MEM_Allow_in;
    logic         WB_Allow_in;
    logic         MEM_to_WB_Valid;
    logic [69:0]  MEM_to_WB_Bus;
    logic [38:0]  rdw_MEM_Bus;
    logic [31:0]  Address;
    logic         MemRead;
    logic         MemWrite;
    logic [31:0]  Write_data;
    logic [3:0]   Write_strb;
    logic         Mem_Req_Ready;
    logic [31:0]  Read_data;
    logic         Read_data_Valid;
    logic         Read_data_Ready;
`ifdef MEM_STALL_CNT_EN
    logic [31:0]  mem_stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .EX_to_MEM_Valid(EX_to_MEM_Valid), .EX_to_MEM_Bus(EX_to_MEM_Bus),
        .MEM_Allow_in(MEM_Allow_in), .WB_Allow_in(WB_Allow_in),
        .MEM_to_WB_Valid(MEM_to_WB_Valid), .MEM_to_WB_Bus(MEM_to_WB_Bus),
        .rdw_MEM_Bus(rdw_MEM_Bus), .Address(Address),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .Write_data(Write_data), .Write_strb(Write_strb),
        .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
        .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready)
`ifdef MEM_STALL_CNT_EN
        , .mem_stall_cnt(mem_stall_cnt)
`endif
    );

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    logic [69:0] wb_q[$];
    req_t        req_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_wb_seen = 0;
    int          n_issued = 0;

    logic        cur_mr, cur_mw, cur_wen;
    logic [2:0]  cur_f3;
    logic [4:0]  cur_wa;
    logic [31:0] cur_alu, cur_sd, cur_pc;
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    logic        pend = 1'b0;
    int          pend_delay = 0;
    logic [31:0] pend_addr = 32'd0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents are a fixed hash of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] alu,
                                             input logic [2:0] f3);
        int          off;
        logic [31:0] v;
        off = int'(alu % 32'd4);
        case (f3)
            3'd0, 3'd4: begin
                v = (word >> (8 * off)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
            end
            3'd1, 3'd5: begin
                v = (word >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        req_t r;
        r.is_write = w; r.addr = a; r.wdata = d; r.strb = s;
        req_q.push_back(r);
    endtask

    task automatic push_expect();
        logic [31:0] fin;
        logic [31:0] word_addr;
        int          off;
        logic [31:0] wd;
        logic [3:0]  st;
        word_addr = cur_alu - (cur_alu % 32'd4);
        off = int'(cur_alu % 32'd4);
        fin = cur_alu;
        if (cur_mr) fin = ref_load(mem_word(word_addr), cur_alu, cur_f3);
        wb_q.push_back({cur_wen, cur_wa, fin, cur_pc});
        if (cur_mr || cur_mw) begin
            wd = cur_sd << (8 * off);
            if (cur_f3 == 3'd0)      st = 4'(1 << off);
            else if (cur_f3 == 3'd1) st = 4'(3 << (2 * (off / 2)));
            else                     st = 4'd15;
            push_req(cur_mw, word_addr, wd, st);
        end
    endtask

    task automatic set_instr(input logic mr, input logic mw, input logic [2:0] f3, input logic wen,
                             input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] sd,
                             input logic [31:0] pc);
        cur_mr = mr; cur_mw = mw; cur_f3 = f3; cur_wen = wen;
        cur_wa = wa; cur_alu = alu; cur_sd = sd; cur_pc = pc;
        EX_to_MEM_Bus = {mr, mw, f3, wen, wa, alu, sd, pc};
    endtask

    task automatic new_instr();
        int kind;
        logic [2:0] f3;
        kind = $urandom_range(0, 2);
        if (kind == 1)      f3 = ld_f3[$urandom_range(0, 4)];
        else if (kind == 2) f3 = 3'($urandom_range(0, 2));
        else                f3 = 3'($urandom);
        set_instr(kind == 1, kind == 2, f3, 1'($urandom), 5'($urandom), $urandom, $urandom,
                  $urandom & 32'hFFFFFFFC);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of randomized traffic: observe handshakes before the edge, drive after it
    task automatic rand_cycle(input bit allow_new);
        bit          ex_fire, req_fire, req_rd, resp_fire;
        logic [31:0] req_addr;
        @(negedge clk);
        ex_fire   = EX_to_MEM_Valid && MEM_Allow_in;
        req_fire  = (MemRead || MemWrite) && Mem_Req_Ready;
        req_rd    = MemRead;
        req_addr  = Address;
        resp_fire = Read_data_Valid && Read_data_Ready;
        if (ex_fire) begin
            push_expect();
            n_issued++;
        end
        tick();
        if (resp_fire) pend = 1'b0;
        if (req_fire && req_rd) begin
            pend = 1'b1;
            pend_addr = req_addr;
            pend_delay = $urandom_range(0, 3);
        end
        if (ex_fire || !EX_to_MEM_Valid) begin
            if (allow_new && $urandom_range(0, 9) < 7) begin
                new_instr();
                EX_to_MEM_Valid = 1'b1;
            end else begin
                EX_to_MEM_Valid = 1'b0;
            end
        end
        WB_Allow_in   = ($urandom_range(0, 3) != 0);
        Mem_Req_Ready = 1'($urandom_range(0, 1));
        if (pend && pend_delay == 0) begin
            Read_data_Valid = 1'b1;
            Read_data = mem_word(pend_addr);
        end else begin
            if (pend) pend_delay--;
            Read_data_Valid = !pend && ($urandom_range(0, 3) == 0);
            Read_data = $urandom;
        end
    endtask

    // Monitor: pops expectations whenever the DUT hands off a result or a memory request
    initial begin
        logic [69:0] e;
        req_t        r;
        forever begin
            @(negedge clk);
            if (MEM_to_WB_Valid && WB_Allow_in) begin
                n_wb_seen++;
                check("wb_q_nonempty", 70'(wb_q.size() != 0), 70'd1);
                if (wb_q.size() != 0) begin
                    e = wb_q.pop_front();
                    check("wb_bus", MEM_to_WB_Bus, e);
                    check("rdw_bus", 70'(rdw_MEM_Bus), 70'({1'b1, e[69], e[68:64], e[63:32]}));
                end
            end
            if ((MemRead || MemWrite) && Mem_Req_Ready) begin
                check("req_q_nonempty", 70'(req_q.size() != 0), 70'd1);
                if (req_q.size() != 0) begin
                    r = req_q.pop_front();
                    check("req_type", 70'({MemRead, MemWrite}), 70'(r.is_write ? 2'b01 : 2'b10));
                    check("req_addr", 70'(Address), 70'(r.addr));
                    if (r.is_write)
                        check("req_wdata_strb", 70'({Write_data, Write_strb}), 70'({r.wdata, r.strb}));
                end
            end
            if (MemRead || Read_data_Ready)
                check("rdw_not_ready", 70'(rdw_MEM_Bus[38]), 70'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;
        rst = 1'b1;
        EX_to_MEM_Valid = 1'b0; EX_to_MEM_Bus = '0; WB_Allow_in = 1'b0;
        Mem_Req_Ready = 1'b0; Read_data = 32'd0; Read_data_Valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 70'({MEM_Allow_in, MEM_to_WB_Valid, MemRead, MemWrite, Read_data_Ready}),
              70'(5'b10000));
        tick();
        rst = 1'b0;

        // ALU op passes through with one cycle of latency
        set_instr(1'b0, 1'b0, 3'd0, 1'b1, 5'd5, 32'h55, 32'h0, 32'h100);
        EX_to_MEM_Valid = 1'b1; WB_Allow_in = 1'b1;
        wb_q.push_back({1'b1, 5'd5, 32'h55, 32'h100});
        tick();
        EX_to_MEM_Valid = 1'b0;
        @(negedge clk);
        check("alu_valid_next", 70'({MEM_to_WB_Valid, MemRead}), 70'(2'b10));
        tick();

        // Back-to-back ALU ops
        set_instr(1'b0, 1'b0, 3'd0, 1'b1, 5'd6, 32'h11, 32'h0, 32'h104);
        EX_to_MEM_Valid = 1'b1;
        wb_q.push_back({1'b1, 5'd6, 32'h11, 32'h104});
        tick();
        set_instr(1'b0, 1'b0, 3'd0, 1'b1, 5'd7, 32'h22, 32'h0, 32'h108);
        wb_q.push_back({1'b1, 5'd7, 32'h22, 32'h108});
        @(negedge clk);
        check("b2b_allow", 70'({MEM_Allow_in, MEM_to_WB_Valid}), 70'(2'b11));
        tick();
        EX_to_MEM_Valid = 1'b0;
        @(negedge clk);
        check("b2b_second", 70'(MEM_to_WB_Valid), 70'd1);
        tick();

        // LB at 0x1003 with delayed request and response
        set_instr(1'b1, 1'b0, 3'b000, 1'b1, 5'd8, 32'h1003, 32'h0, 32'h200);
        EX_to_MEM_Valid = 1'b1; Mem_Req_Ready = 1'b0;
        push_req(1'b0, 32'h1000, 32'h0, 4'h0);
        wb_q.push_back({1'b1, 5'd8, 32'hFFFFFF80, 32'h200});
        tick();
        EX_to_MEM_Valid = 1'b0;
        @(negedge clk);
        check("lb_req", 70'({MemRead, MemWrite, Address}), 70'({1'b1, 1'b0, 32'h1000}));
        tick();
        tick();
        Mem_Req_Ready = 1'b1;
        tick();
        Mem_Req_Ready = 1'b0;
        tick();
        tick();
        Read_data = 32'h80112233; Read_data_Valid = 1'b1;
        tick();
        Read_data_Valid = 1'b0;
        @(negedge clk);
        check("lb_done", 70'(MEM_to_WB_Valid), 70'd1);
        tick();

        // SH at 0x2002
        set_instr(1'b0, 1'b1, 3'b001, 1'b0, 5'd9, 32'h2002, 32'h0000BEEF, 32'h300);
        EX_to_MEM_Valid = 1'b1; Mem_Req_Ready = 1'b1;
        push_req(1'b1, 32'h2000, 32'hBEEF0000, 4'b1100);
        wb_q.push_back({1'b0, 5'd9, 32'h2002, 32'h300});
        tick();
        EX_to_MEM_Valid = 1'b0;
        @(negedge clk);
        check("sh_strb_data", 70'({Write_strb, Write_data}), 70'({4'b1100, 32'hBEEF0000}));
        tick();
        Mem_Req_Ready = 1'b0;
        @(negedge clk);
        check("sh_done", 70'(MEM_to_WB_Valid), 70'd1);
        tick();

        // LW completes while writeback is blocked for four cycles
        set_instr(1'b1, 1'b0, 3'b010, 1'b1, 5'd10, 32'h3000, 32'h0, 32'h400);
        EX_to_MEM_Valid = 1'b1; WB_Allow_in = 1'b0; Mem_Req_Ready = 1'b1;
        Read_data = 32'hCAFEF00D;
        push_req(1'b0, 32'h3000, 32'h0, 4'h0);
        wb_q.push_back({1'b1, 5'd10, 32'hCAFEF00D, 32'h400});
        tick();
        EX_to_MEM_Valid = 1'b0;
        tick();
        Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b1;
        tick();
        Read_data_Valid = 1'b0;
        set_instr(1'b0, 1'b0, 3'd0, 1'b1, 5'd11, 32'h77, 32'h0, 32'h404);
        EX_to_MEM_Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lw_hold_ctl", 70'({MEM_to_WB_Valid, MEM_Allow_in}), 70'(2'b10));
            check("lw_hold_bus", MEM_to_WB_Bus, {1'b1, 5'd10, 32'hCAFEF00D, 32'h400});
            tick();
        end
        seen0 = n_wb_seen;
        WB_Allow_in = 1'b1;
        wb_q.push_back({1'b1, 5'd11, 32'h77, 32'h404});
        tick();
        EX_to_MEM_Valid = 1'b0;
        tick();
        @(negedge clk);
        check("lw_release_transfers", 70'(n_wb_seen - seen0), 70'd2);
        check("lw_release_idle", 70'(MEM_to_WB_Valid), 70'd0);
        tick();

        // Reset during RESP; a later response must be dropped
        set_instr(1'b1, 1'b0, 3'b010, 1'b1, 5'd12, 32'h5000, 32'h0, 32'h500);
        EX_to_MEM_Valid = 1'b1; Mem_Req_Ready = 1'b1;
        push_req(1'b0, 32'h5000, 32'h0, 4'h0);
        tick();
        EX_to_MEM_Valid = 1'b0;
        tick();
        Mem_Req_Ready = 1'b0;
        @(negedge clk);
        check("resp_state", 70'(Read_data_Ready), 70'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_load", 70'({MEM_Allow_in, MEM_to_WB_Valid, Read_data_Ready}), 70'(3'b100));
        tick();
        rst = 1'b0; Read_data = 32'h12345678; Read_data_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drop_late_resp", 70'({MEM_to_WB_Valid, MEM_Allow_in, Read_data_Ready}),
                  70'(3'b010));
            tick();
        end
        Read_data_Valid = 1'b0;
        check("no_stale_wb", 70'(wb_q.size()), 70'd0);

`ifdef MEM_STALL_CNT_EN
        // Load with two REQ and three RESP cycles after a reset
        @(negedge clk);
        check("stall_cnt_zero", 70'(mem_stall_cnt), 70'd0);
        tick();
        set_instr(1'b1, 1'b0, 3'b010, 1'b1, 5'd13, 32'h6000, 32'h0, 32'h600);
        EX_to_MEM_Valid = 1'b1; Mem_Req_Ready = 1'b0; Read_data = 32'h0BADBEEF;
        push_req(1'b0, 32'h6000, 32'h0, 4'h0);
        wb_q.push_back({1'b1, 5'd13, 32'h0BADBEEF, 32'h600});
        tick();
        EX_to_MEM_Valid = 1'b0;
        tick();
        Mem_Req_Ready = 1'b1;
        tick();
        Mem_Req_Ready = 1'b0;
        tick();
        tick();
        Read_data_Valid = 1'b1;
        tick();
        Read_data_Valid = 1'b0;
        @(negedge clk);
        check("stall_cnt", 70'(mem_stall_cnt), 70'd5);
        tick();
`endif

        // Randomized traffic
        for (int c = 0; c < 8000 && n_issued < 300; c++) rand_cycle(1'b1);
        check("issued_all", 70'(n_issued), 70'd300);
        for (int c = 0; c < 300 && (wb_q.size() != 0 || req_q.size() != 0 || EX_to_MEM_Valid); c++)
            rand_cycle(1'b0);
        check("drain_wb_q", 70'(wb_q.size()), 70'd0);
        check("drain_req_q", 70'(req_q.size()), 70'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: MEM_Stage

Interface
REQ-001 SHALL define parameter macro EX_TO_MEM_BUS_WD, default 107, width of the EX-to-MEM bus.
REQ-002 SHALL define MEM_TO_WB_BUS_WD = 70 and RDW_BUS_WD = 39.
REQ-003 Ports SHALL be as follows; clock/reset: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- EX_to_MEM_Valid  in  1  upstream holds a valid instruction
- EX_to_MEM_Bus  in  107  {MemRead, MemWrite, funct3[2:0], WB_wen, RF_waddr[4:0], alu_result[31:0], store_data[31:0], PC[31:0]} (MSB first)
- MEM_Allow_in  out  1  stage can accept this cycle
- WB_Allow_in  in  1  downstream can accept
- MEM_to_WB_Valid  out  1  MEM_to_WB_Bus valid
- MEM_to_WB_Bus  out  70  {WB_wen, RF_waddr, final_result, PC}
- rdw_MEM_Bus  out  39  {data_ready, RF_wen, RF_waddr, final_result} bypass to ID
- Address  out  32  word-aligned address {alu_result[31:2],2'b00}
- MemRead / MemWrite  out  1  request strobes
- Write_data  out  32  lane-shifted store data
- Write_strb  out  4  byte enables
- Mem_Req_Ready  in  1  memory accepts request
- Read_data  in  32  load response data
- Read_data_Valid  in  1  response valid
- Read_data_Ready  out  1  stage accepts response

Function
REQ-004 SHALL latch EX_to_MEM_Bus into an internal register on the cycle EX_to_MEM_Valid & MEM_Allow_in; register SHALL hold otherwise.
REQ-005 SHALL implement FSM states IDLE, REQ, RESP, DONE; MEM_Valid = (state != IDLE).
REQ-006 On accept: MemRead|MemWrite -> REQ; else -> DONE (zero extra latency for ALU ops).
REQ-007 REQ: MemRead/MemWrite asserted per latched type; on Mem_Req_Ready, load -> RESP, store -> DONE.
REQ-008 RESP: Read_data_Ready=1; on Read_data_Valid latch extended data, -> DONE.
REQ-009 DONE: MEM_to_WB_Valid=1; on WB_Allow_in, -> REQ/DONE if new instruction accepted same cycle, else IDLE.
REQ-010 MEM_Allow_in = (state==IDLE) | (state==DONE & WB_Allow_in); back-to-back ALU ops SHALL flow at one per cycle.
REQ-011 Load extension by funct3 and offset=alu_result[1:0]: 000 LB sign, 100 LBU zero (byte offset*8), 001 LH sign, 101 LHU zero (half at offset[1]*16), 010 LW whole word.
REQ-012 Store: SB strb 0001<<offset, SH 0011<<{offset[1],0}, SW 1111; Write_data = store_data << (offset*8), upper bits truncated.
REQ-013 final_result = loaded data for loads, alu_result otherwise.
REQ-014 rdw_MEM_Bus: data_ready = 0 while a load is in REQ/RESP, else 1; RF_wen = MEM_Valid & WB_wen.
REQ-015 Misaligned offsets SHALL be handled per REQ-011/012 without trap.
REQ-016 Mem_Req_Ready and Read_data_Valid outside REQ/RESP SHALL be ignored.

Reset
REQ-017 rst SHALL asynchronously force state=IDLE; MEM_to_WB_Valid, MemRead, MemWrite, Read_data_Ready = 0; MEM_Allow_in = 1.
REQ-018 Reset mid-load (REQ or RESP) SHALL abandon the instruction; a response arriving after reset release SHALL be dropped.
REQ-019 Data registers need no reset value.

Configuration
REQ-020 Macro MEM_STALL_CNT_EN: when defined, SHALL add output mem_stall_cnt[31:0], reset 0, incremented each cycle state is REQ or RESP, wrapping at 2^32-1 -> 0; when undefined, port and counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-021 ALU op PC=0x100, alu_result=0x55, WB_Allow_in=1 -> MEM_to_WB_Valid next cycle, final_result=0x55, no MemRead.
REQ-022 LB addr 0x1003, Read_data=0x80112233, Mem_Req_Ready after 2 cycles, Read_data_Valid after 3 -> final_result=0xFFFFFF80, Address=0x1000.
REQ-023 SH addr 0x2002, store_data=0x0000BEEF -> Write_strb=1100, Write_data=0xBEEF0000, DONE after Mem_Req_Ready.
REQ-024 LW completes while WB_Allow_in=0 for 4 cycles -> DONE held, MEM_Allow_in=0, bus stable; release -> one transfer only.
REQ-025 rst pulse during RESP, then Read_data_Valid=1 -> no MEM_to_WB_Valid, state IDLE.
REQ-026 With MEM_STALL_CNT_EN, load with 5 stall cycles from reset -> mem_stall_cnt=5.
